// File: rtl/countdown_bomb_pkg.sv
// Shared state encoding and State_Out width for the countdown bomb timer.
package countdown_bomb_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      StIdle     = 3'd0,
      StRun      = 3'd1,
      StPaused   = 3'd2,
      StExploded = 3'd3,
      StDisarmed = 3'd4
   } state_e;

endpackage

// File: rtl/countdown_bomb_timer_tick_prescaler.sv
// Divides the clock into a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic enable_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign tick_o = enable_i && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/countdown_bomb_timer.sv
// Parametrised countdown bomb timer with pause/resume, warning window and sticky detonation.
// Define DISARM_CODE_EN to add the coded disarm path with a strike limit.
module countdown_bomb_timer
   import countdown_bomb_pkg::*;
#(
   parameter int unsigned COUNT_W     = 5,
   parameter int unsigned START_COUNT = 15,
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned WARN_COUNT  = 3
`ifdef DISARM_CODE_EN
   ,
   parameter int unsigned        CODE_W      = 4,
   parameter logic [CODE_W-1:0]  DISARM_CODE = CODE_W'('hA),
   parameter int unsigned        MAX_STRIKES = 3
`endif
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Clear,
`ifdef DISARM_CODE_EN
   input  logic               Disarm_Valid,
   input  logic [CODE_W-1:0]  Disarm_Code,
`endif
   output logic [COUNT_W-1:0] Counter_Out,
   output logic               Blow_Up,
   output logic               Warning,
   output logic [STATE_W-1:0] State_Out
);

   if (START_COUNT < 1 || 64'(START_COUNT) > ((64'(1) << COUNT_W) - 1)) begin : g_bad_start
      $error("START_COUNT must lie in 1 .. 2**COUNT_W-1");
   end
   if (TICK_DIV < 1) begin : g_bad_div
      $error("TICK_DIV must be at least 1");
   end
`ifdef DISARM_CODE_EN
   if (MAX_STRIKES < 1) begin : g_bad_strikes
      $error("MAX_STRIKES must be at least 1");
   end
   localparam int unsigned STRIKE_W = $clog2(MAX_STRIKES + 1);
   logic [STRIKE_W-1:0] strikes_q, strikes_d;
`endif

   localparam logic [COUNT_W-1:0] START_LOAD = COUNT_W'(START_COUNT);

   state_e             state_q, state_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               blow_q, blow_d;
   logic               tick;
   logic               handled;

   // Stop freezes the prescaler on its own edge so a paused tick is not lost.
   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .Clock    (Clock),
      .Reset    (Reset),
      .enable_i ((state_q == StRun) && !Stop),
      .clear_i  (state_q == StIdle),
      .tick_o   (tick)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      blow_d  = blow_q;
      handled = 1'b0;
`ifdef DISARM_CODE_EN
      strikes_d = strikes_q;
      if ((state_q == StRun || state_q == StPaused) && Disarm_Valid) begin
         if (Disarm_Code == DISARM_CODE) begin
            state_d = StDisarmed;
            handled = 1'b1;
         end else begin
            strikes_d = strikes_q + 1'b1;
            if (32'(strikes_d) >= MAX_STRIKES) begin
               state_d = StExploded;
               count_d = '0;
               blow_d  = 1'b1;
               handled = 1'b1;
            end
         end
      end
`endif
      if (!handled) begin
         unique case (state_q)
            StIdle: begin
               if (Start) state_d = StRun;
            end
            StRun: begin
               if (Stop) begin
                  state_d = StPaused;
               end else if (tick && count_q != '0) begin
                  count_d = count_q - 1'b1;
                  if (count_q == COUNT_W'(1)) begin
                     state_d = StExploded;
                     blow_d  = 1'b1;
                  end
               end
            end
            StPaused: begin
               if (Clear) begin
                  state_d = StIdle;
                  count_d = START_LOAD;
               end else if (Start && !Stop) begin
                  state_d = StRun;
               end
            end
            StExploded: ;
`ifdef DISARM_CODE_EN
            StDisarmed: begin
               if (Clear) begin
                  state_d = StIdle;
                  count_d = START_LOAD;
               end
            end
`endif
            default: begin
               state_d = StIdle;
               count_d = START_LOAD;
               blow_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
         count_q <= START_LOAD;
         blow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         blow_q  <= blow_d;
      end
   end

`ifdef DISARM_CODE_EN
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         strikes_q <= '0;
      end else begin
         strikes_q <= strikes_d;
      end
   end
`endif

   assign Counter_Out = count_q;
   assign Blow_Up     = blow_q;
   assign State_Out   = state_q;
   assign Warning     = (state_q == StRun || state_q == StPaused) && (count_q != '0) &&
                        (32'(count_q) <= WARN_COUNT);

endmodule
